// File: rtl/const_mac_neuron_pkg.sv
// ---------------------------------------------------------------------------
// const_mac_neuron_pkg
// Shared types and elaboration helpers for the constant-weight MAC neuron.
//   state_t   : neuron control states (IDLE, ACCUM, FLUSH, DONE)
//   act_t     : signed activation at the default width
//   prod_t    : full-precision signed product at the default width
//   acc_width : accumulator width that cannot overflow for N_IN products
//   idx_width : width of the arrival-index counter (at least 1 bit)
// ---------------------------------------------------------------------------
package const_mac_neuron_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_N_IN  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef logic signed [DEF_WIDTH-1:0]   act_t;
  typedef logic signed [2*DEF_WIDTH-1:0] prod_t;

  // Sum of n_in full-precision products plus a bias needs clog2(n_in)+1
  // guard bits on top of the product width.
  function automatic int acc_width(input int width, input int n_in);
    return 2 * width + $clog2(n_in) + 1;
  endfunction

  // A single-input neuron still carries a 1-bit index that stays at zero.
  function automatic int idx_width(input int n_in);
    return (n_in > 1) ? $clog2(n_in) : 1;
  endfunction

endpackage

// File: rtl/const_mac_neuron_if.sv
// ---------------------------------------------------------------------------
// const_mac_neuron_if
// Input activation stream and output result stream of the MAC neuron.
//   in_data/in_valid/in_ready    : activation stream (producer -> neuron)
//   out_data/out_valid/out_ready : result stream (neuron -> consumer)
// Modports:
//   master : the surrounding fabric (drives activations, accepts results)
//   slave  : the neuron itself
// ---------------------------------------------------------------------------
interface const_mac_neuron_if
  import const_mac_neuron_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_WIDTH = acc_width(DEF_WIDTH, DEF_N_IN)
);

  logic signed [WIDTH-1:0]     in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic signed [ACC_WIDTH-1:0] out_data;
  logic                        out_valid;
  logic                        out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/const_mac_neuron_indexed_const_mul.sv
// ---------------------------------------------------------------------------
// indexed_const_mul
// Stage 1 of the neuron pipeline: multiplies the accepted activation by the
// compile-time weight selected by its arrival index and registers the
// full-precision product.
//   clk, rst   : clock, synchronous active-high reset
//   idx        : arrival index of the current activation
//   in_data    : signed activation
//   valid      : activation accepted this cycle
//   prod       : registered signed product (2*WIDTH bits)
//   prod_valid : prod holds a fresh product
// ---------------------------------------------------------------------------
module indexed_const_mul
  import const_mac_neuron_pkg::*;
#(
  parameter int                    WIDTH   = DEF_WIDTH,
  parameter int                    N_IN    = DEF_N_IN,
  parameter int                    IDX_W   = idx_width(N_IN),
  parameter logic [N_IN*WIDTH-1:0] WEIGHTS = {16'sh0005, 16'sh0000, 16'sh0003, 16'shfff8}
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [IDX_W-1:0]            idx,
  input  logic signed [WIDTH-1:0]     in_data,
  input  logic                        valid,
  output logic signed [2*WIDTH-1:0]   prod,
  output logic                        prod_valid
);

  logic signed [WIDTH-1:0]   weight_s;
  logic signed [2*WIDTH-1:0] in_ext_s;
  logic signed [2*WIDTH-1:0] w_ext_s;
  logic signed [2*WIDTH-1:0] prod_s;
  logic signed [2*WIDTH-1:0] prod_r;
  logic                      prod_valid_r;

  // Weight lookup; an out-of-range index (unreachable) reads as zero weight.
  always_comb begin
    weight_s = {WIDTH{1'b0}};
    if (int'(idx) < N_IN) begin
      weight_s = WEIGHTS[idx*WIDTH +: WIDTH];
    end else begin
      weight_s = {WIDTH{1'b0}};
    end
  end

  // Both operands are sign-extended first so the 2*WIDTH product is exact.
  assign in_ext_s = {{WIDTH{in_data[WIDTH-1]}}, in_data};
  assign w_ext_s  = {{WIDTH{weight_s[WIDTH-1]}}, weight_s};
  assign prod_s   = in_ext_s * w_ext_s;

  // Product register; only loads on an accept so prod is stable otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_r       <= {(2*WIDTH){1'b0}};
      prod_valid_r <= 1'b0;
    end else begin
      prod_valid_r <= valid;
      if (valid) begin
        prod_r <= prod_s;
      end
    end
  end

  assign prod       = prod_r;
  assign prod_valid = prod_valid_r;

endmodule

// File: rtl/const_mac_neuron.sv
// ---------------------------------------------------------------------------
// const_mac_neuron
// Serial constant-weight neuron: accepts N_IN signed activations, multiplies
// the i-th by WEIGHTS[i], accumulates onto BIAS and presents one signed
// result per vector. The last accept at edge t yields out_valid after t+1.
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   busy : high in every state except IDLE
//   bus  : slave side of const_mac_neuron_if (activation + result streams)
// Build option:
//   CONST_MAC_NEURON_RELU_EN : clamp negative results to zero at the
//   output register (accumulator itself keeps the raw sum).
// ---------------------------------------------------------------------------
module const_mac_neuron
  import const_mac_neuron_pkg::*;
#(
  parameter int                      WIDTH     = DEF_WIDTH,
  parameter int                      N_IN      = DEF_N_IN,
  parameter int                      ACC_WIDTH = acc_width(WIDTH, N_IN),
  parameter logic [N_IN*WIDTH-1:0]   WEIGHTS   = {16'sh0005, 16'sh0000, 16'sh0003, 16'shfff8},
  parameter logic signed [WIDTH-1:0] BIAS      = 16'sd10
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  const_mac_neuron_if.slave bus
);

  localparam int                          IDX_W    = idx_width(N_IN);
  localparam logic [IDX_W-1:0]            LAST_IDX = IDX_W'(N_IN - 1);
  localparam logic signed [ACC_WIDTH-1:0] BIAS_EXT = {{(ACC_WIDTH-WIDTH){BIAS[WIDTH-1]}}, BIAS};

  state_t                      state_r;
  state_t                      state_nxt_s;
  logic [IDX_W-1:0]            idx_r;
  logic                        in_ready_s;
  logic                        accept_s;
  logic                        last_s;
  logic                        out_fire_s;
  logic signed [2*WIDTH-1:0]   prod_s;
  logic                        prod_valid_s;
  logic signed [ACC_WIDTH-1:0] prod_ext_s;
  logic signed [ACC_WIDTH-1:0] sum_s;
  logic signed [ACC_WIDTH-1:0] result_s;
  logic signed [ACC_WIDTH-1:0] acc_r;
  logic signed [ACC_WIDTH-1:0] out_data_r;
  logic                        out_valid_r;

  assign in_ready_s = (state_r == ST_IDLE) || (state_r == ST_ACCUM);
  assign accept_s   = bus.in_valid && in_ready_s;
  assign last_s     = (idx_r == LAST_IDX);
  assign out_fire_s = out_valid_r && bus.out_ready;

  indexed_const_mul #(
    .WIDTH   (WIDTH),
    .N_IN    (N_IN),
    .IDX_W   (IDX_W),
    .WEIGHTS (WEIGHTS)
  ) u_mul (
    .clk        (clk),
    .rst        (rst),
    .idx        (idx_r),
    .in_data    (bus.in_data),
    .valid      (accept_s),
    .prod       (prod_s),
    .prod_valid (prod_valid_s)
  );

  // Stage 2 adder: adds the pending product, if any, to the running sum.
  always_comb begin
    prod_ext_s = {ACC_WIDTH{1'b0}};
    if (prod_valid_s) begin
      prod_ext_s = {{(ACC_WIDTH-2*WIDTH){prod_s[2*WIDTH-1]}}, prod_s};
    end else begin
      prod_ext_s = {ACC_WIDTH{1'b0}};
    end
  end

  assign sum_s = acc_r + prod_ext_s;

  // Value presented at the output; ReLU only affects what leaves the block.
  always_comb begin
    result_s = sum_s;
`ifdef CONST_MAC_NEURON_RELU_EN
    if (sum_s[ACC_WIDTH-1]) begin
      result_s = {ACC_WIDTH{1'b0}};
    end else begin
      result_s = sum_s;
    end
`endif
  end

  // Next-state logic; IDLE and ACCUM share the accept rule (IDLE's idx is 0).
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_ACCUM: begin
        if (accept_s && last_s) begin
          state_nxt_s = ST_FLUSH;
        end else if (accept_s) begin
          state_nxt_s = ST_ACCUM;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_FLUSH: begin
        state_nxt_s = ST_DONE;
      end
      ST_DONE: begin
        if (out_fire_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Arrival-index counter; wraps to 0 on the last accept of a vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r <= {IDX_W{1'b0}};
    end else if (accept_s && last_s) begin
      idx_r <= {IDX_W{1'b0}};
    end else if (accept_s) begin
      idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
    end
  end

  // Accumulator; reloads the bias when the result is handed off.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= BIAS_EXT;
    end else if (out_fire_s) begin
      acc_r <= BIAS_EXT;
    end else if (prod_valid_s) begin
      acc_r <= sum_s;
    end
  end

  // Output register: captured in FLUSH (final product folded in the same
  // edge), held until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {ACC_WIDTH{1'b0}};
    end else if (state_r == ST_FLUSH) begin
      out_valid_r <= 1'b1;
      out_data_r  <= result_s;
    end else if (out_fire_s) begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign busy          = (state_r != ST_IDLE);

endmodule

// File: tb/tb_const_mac_neuron.sv
module tb_const_mac_neuron;
  import const_mac_neuron_pkg::*;

  localparam int WIDTH = 16;
  localparam int N_IN  = 4;
  localparam int ACC_W = 35;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic busy2;

  always #5 clk = ~clk;

  const_mac_neuron_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_W)) bus ();
  const_mac_neuron_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_W)) bus2 ();

  const_mac_neuron #(.WIDTH(WIDTH), .N_IN(N_IN)) dut (
    .clk  (clk),
    .rst  (rst),
    .busy (busy),
    .bus  (bus)
  );

  const_mac_neuron #(
    .WIDTH   (WIDTH),
    .N_IN    (N_IN),
    .WEIGHTS ({4{16'h8000}}),
    .BIAS    (16'sd0)
  ) dut_big (
    .clk  (clk),
    .rst  (rst),
    .busy (busy2),
    .bus  (bus2)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: a vector is a list of accepted samples; the
  // result is BIAS + sum(w[i]*x[i]); it appears two edges after the last
  // accept and stays until the consumer takes it. No input is taken while
  // a finished vector is waiting.
  int     w_tab [4] = '{-8, 3, 0, 5};
  localparam longint BIAS_V = 10;
  int     m_cnt    = 0;
  longint m_sum    = BIAS_V;
  bit     m_closed = 1'b0;
  int     m_age    = 0;

  function automatic longint exp_result(input longint s);
`ifdef CONST_MAC_NEURON_RELU_EN
    return (s < 0) ? 64'sd0 : s;
`else
    return s;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_cnt    <= 0;
      m_sum    <= BIAS_V;
      m_closed <= 1'b0;
      m_age    <= 0;
    end else if (m_closed) begin
      if (m_age == 0) begin
        m_age <= 1;
      end else if (bus.out_ready) begin
        m_closed <= 1'b0;
        m_cnt    <= 0;
        m_sum    <= BIAS_V;
      end
    end else if (bus.in_valid) begin
      m_sum <= m_sum + longint'(w_tab[m_cnt]) * longint'(bus.in_data);
      m_cnt <= m_cnt + 1;
      if (m_cnt == N_IN - 1) begin
        m_closed <= 1'b1;
        m_age    <= 0;
      end
    end
  end

  // Per-cycle comparison of the main DUT against the reference.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", longint'(bus.in_ready), longint'(!m_closed));
      chk("out_valid", longint'(bus.out_valid), longint'(m_closed && m_age >= 1));
      chk("busy", longint'(busy), longint'(m_closed || m_cnt != 0));
      if (m_closed && m_age >= 1) begin
        chk("out_data", longint'($signed(bus.out_data)), exp_result(m_sum));
      end
    end
  end

  // gap_mode: 0 back-to-back, 1 valid toggles 1-0-1-0, 2 random gaps.
  task automatic send_vec(input int v [4], input int gap_mode);
    bit tog;
    tog = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bit done;
      int guard;
      done  = 1'b0;
      guard = 0;
      while (!done && guard < 50) begin
        @(negedge clk);
        guard++;
        bus.in_data = act_t'(v[i]);
        if (gap_mode == 1) begin
          bus.in_valid = tog;
          tog = !tog;
        end else if (gap_mode == 2) begin
          bus.in_valid = ($urandom_range(0, 3) != 0);
        end else begin
          bus.in_valid = 1'b1;
        end
        if (!bus.in_valid) bus.in_data = act_t'($urandom);
        done = bus.in_valid && !m_closed;
      end
    end
  endtask

  task automatic wait_out(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      bus.in_valid = 1'b0;
    end while (!bus.out_valid && k < 10);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (m_closed && g < 200) begin
      @(negedge clk);
      g++;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'($urandom_range(0, 1));
    end
    chk("drain_timeout", longint'(m_closed), 64'sd0);
  endtask

  int vec [4];
  int k;

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.in_data   = '0;
    bus2.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", longint'(bus.in_ready), 64'sd1);
    chk("rst_out_valid", longint'(bus.out_valid), 64'sd0);
    chk("rst_out_data", longint'($signed(bus.out_data)), 64'sd0);
    chk("rst_busy", longint'(busy), 64'sd0);

    // Back-to-back vector
    vec = '{-26, 4, 100, -2};
    send_vec(vec, 0);
    wait_out(k);
    chk("v1_latency", longint'(k), 64'sd2);
    chk("v1_data", longint'($signed(bus.out_data)), 64'sd220);
    @(negedge clk);
    chk("v1_single_pulse", longint'(bus.out_valid), 64'sd0);

    // Negative sum
    vec = '{26, 0, 0, 0};
    send_vec(vec, 0);
    wait_out(k);
`ifdef CONST_MAC_NEURON_RELU_EN
    chk("v2_data_relu", longint'($signed(bus.out_data)), 64'sd0);
`else
    chk("v2_data", longint'($signed(bus.out_data)), -64'sd198);
`endif
    @(negedge clk);

    // Toggling in_valid
    vec = '{-26, 4, 100, -2};
    send_vec(vec, 1);
    wait_out(k);
    chk("v3_latency", longint'(k), 64'sd2);
    chk("v3_data", longint'($signed(bus.out_data)), 64'sd220);
    @(negedge clk);

    // Back-pressure in DONE with in_valid pulses
    bus.out_ready = 1'b0;
    send_vec(vec, 0);
    wait_out(k);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'(i % 2);
      bus.in_data  = act_t'($urandom);
      chk("hold_valid", longint'(bus.out_valid), 64'sd1);
      chk("hold_data", longint'($signed(bus.out_data)), 64'sd220);
      chk("hold_in_ready", longint'(bus.in_ready), 64'sd0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("hold_release", longint'(bus.out_valid), 64'sd0);
    chk("hold_idle_ready", longint'(bus.in_ready), 64'sd1);

    // Reset in the middle of a vector
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'sd7;
    @(negedge clk);
    bus.in_data  = 16'sd7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", longint'(busy), 64'sd0);
    vec = '{1, 1, 1, 1};
    send_vec(vec, 0);
    wait_out(k);
    chk("midrst_data", longint'($signed(bus.out_data)), 64'sd10);
    @(negedge clk);

    // Random vectors, random gaps, random consumer stalls
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 4; i++) vec[i] = int'(act_t'($urandom));
      send_vec(vec, 2);
      drain();
    end
    bus.out_ready = 1'b1;

    // Extreme operands on the second instance
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus2.in_valid = 1'b1;
      bus2.in_data  = 16'sh8000;
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
      bus2.in_valid = 1'b0;
    end while (!bus2.out_valid && k < 10);
    chk("big_latency", longint'(k), 64'sd2);
    chk("big_data", longint'($signed(bus2.out_data)), 64'sd4294967296);
    @(negedge clk);
    chk("big_pulse", longint'(bus2.out_valid), 64'sd0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/const_mac_neuron.md
Name: const_mac_neuron

Overview:
- Sequential successor to the combinational constant-weight multiplier.
- Accepts N_IN signed activations serially over a valid/ready stream.
- Multiplies each activation by a compile-time weight selected by arrival index, then accumulates onto a compile-time bias.
- Presents one signed neuron result per vector through an output valid/ready handshake. Sits between layer input FIFOs and the next layer in NETWORK1.

Parameters:
- WIDTH, 16, signed activation and weight width.
- N_IN, 4, activations per vector (≥1).
- ACC_WIDTH, 2*WIDTH+$clog2(N_IN)+1, accumulator and output width; guarantees no overflow.
- WEIGHTS, {-8, 3, 0, 5}, signed WIDTH-bit weight array; WEIGHTS[i] multiplies the i-th accepted input.
- BIAS, 10, signed WIDTH-bit bias; sign-extended to ACC_WIDTH.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- in_data, input, WIDTH, signed activation.
- in_valid, input, 1, in_data is valid.
- in_ready, output, 1, block can accept an activation.
- out_data, output, ACC_WIDTH, signed neuron result.
- out_valid, output, 1, out_data is valid.
- out_ready, input, 1, consumer accepts out_data.
- busy, output, 1, high in every state except IDLE.

Behaviour:
- Reset and reset value: synchronous, active-high. rst=1 at a clock edge forces state=IDLE, idx=0, prod_valid=0, acc=sext(BIAS), out_valid=0, out_data=0. in_ready is combinational and equals 1 from IDLE. Reset mid-vector discards the partial sum; the next accepted input is treated as index 0.
- States:
  - IDLE: idx=0, in_ready=1. An accept with N_IN>1 moves to ACCUM; an accept with N_IN==1 moves to FLUSH.
  - ACCUM: in_ready=1. An accept of index N_IN-1 moves to FLUSH.
  - FLUSH: in_ready=0. Exactly one cycle, then DONE.
  - DONE: out_valid=1, in_ready=0. The cycle in which out_valid && out_ready moves to IDLE, reloads acc=sext(BIAS) and clears out_valid.
- Accept: in_valid && in_ready at a rising edge. Gaps in in_valid are allowed and change nothing. in_data is ignored while in_ready=0.
- Pipeline:
  - Stage 1: prod <= in_data * WEIGHTS[idx], full-precision signed 2*WIDTH; prod_valid <= accept; idx++ on accept.
  - Stage 2: when prod_valid, acc <= acc + sext(prod).
  - Back-to-back accepts sustain one input per cycle.
- Latency: last accept at edge t gives out_valid=1 and out_data=final acc after edge t+1. That is 2 cycles, plus or minus nothing.
- out_data is registered and held stable while out_valid=1 && out_ready=0.
- Throughput: N_IN+2 cycles per vector minimum. There is no overlap between consecutive vectors.
- Arithmetic: signed two's complement throughout. Zero weights still consume an input slot. Because ACC_WIDTH covers the worst case, there is no saturation and no wrap.
- Boundary cases:
  - out_ready may be high before out_valid; the handshake completes in the first DONE cycle.
  - in_valid asserted in DONE is held off; the first post-DONE accept occurs no earlier than the cycle after the output handshake.

Optional Feature:
- Macro: CONST_MAC_NEURON_RELU_EN.
- Defined: on the FLUSH→DONE transition, a negative sum produces out_data=0; otherwise out_data equals the sum. acc internally is unchanged.
- Undefined: out_data equals the raw signed sum. Latency is identical in both builds.

Decomposition:
- neuron_pkg:
  - state enum (IDLE, ACCUM, FLUSH, DONE);
  - function clog2-based ACC_WIDTH helper;
  - typedef act_t (signed WIDTH) and prod_t (signed 2*WIDTH).
- One natural sub-module: indexed_const_mul. It takes idx, in_data and valid and returns the registered product and prod_valid, selecting WEIGHTS[idx]. The top holds the FSM, counter and accumulator.

Test Plan:
- Inputs {-26, 4, 100, -2} back-to-back, out_ready=1, default weights and bias -> single out_valid pulse, out_data=220, 2 cycles after the last accept.
- Inputs {26, 0, 0, 0} -> out_data=-198. With CONST_MAC_NEURON_RELU_EN defined -> out_data=0.
- Same vector as scenario 1 with in_valid toggled 1-0-1-0 -> out_data=220, and idx advances only on accepts.
- out_ready held low 5 cycles in DONE -> out_valid and out_data=220 stable; in_ready=0 throughout; in_valid pulses ignored.
- rst asserted after 2 accepts of {7, 7}, then full vector {1, 1, 1, 1} -> out_data=1*(-8+3+0+5)+10=10.
- WIDTH=16, WEIGHTS all -32768, inputs all -32768, BIAS=0 -> out_data=4*2^30=4294967296, with no overflow in the 35-bit ACC_WIDTH.
